// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable: combinational out plus a registered copy out_q.
// Latency: out 0 cycles, out_q 1 cycle; no flow control, so it never applies backpressure.
module decoder_3to8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] in,
  output logic [7:0] out,
  output logic [7:0] out_q
);

  logic [7:0] out_d;

  always_comb begin
    out_d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      out_d[i] = ena && (in == 3'(i));
    end
  end

  assign out = out_d;

  // The reset clears only the registered copy; the combinational path ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 8'h00;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: directed cases followed by random ena/in traffic.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] in_s;
  logic [7:0] out;
  logic [7:0] out_q;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];

  decoder_3to8 dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .in    (in_s),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a one-hot value is 2 raised to the index, or nothing when disabled.
  function automatic logic [7:0] model(input logic e, input logic [2:0] idx);
    int v;
    v = e ? (2 ** int'(idx)) : 0;
    return 8'(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs away from the active edge and queue the registered expectation.
  task automatic step(input logic r, input logic e, input logic [2:0] idx);
    @(negedge clk);
    rst  = r;
    ena  = e;
    in_s = idx;
    #1;
    check("out_comb", out, model(e, idx));
    sb.push_back(r ? 8'h00 : model(e, idx));
  endtask

  // Monitor: out_q is presented once per rising edge.
  always @(posedge clk) begin
    logic [7:0] exp;
    #1;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check("out_q", out_q, exp);
      check("out_q_onehot", 8'($countones(out_q) <= 1), 8'd1);
    end
  end

  initial begin
    rst  = 1'b1;
    ena  = 1'b1;
    in_s = 3'd4;
    #1;
    check("reset_out_q", out_q, 8'h00);
    check("reset_out", out, 8'h10);

    // Held in reset for three clocks while decode is active.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 3'd4);

    // Sweep all codes enabled, then disabled.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'(k));
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 3'(k));
    step(1'b0, 1'b1, 3'd2);

    // Enable and index change together.
    step(1'b0, 1'b1, 3'd3);
    step(1'b0, 1'b0, 3'd6);
    step(1'b0, 1'b1, 3'd6);

    // Asynchronous reset asserted and released between edges.
    step(1'b0, 1'b1, 3'd7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_q", out_q, 8'h00);
    check("async_rst_out", out, 8'h80);
    step(1'b0, 1'b1, 3'd1);
    check("rst_release_hold", out_q, 8'h00);

    for (int k = 0; k < 1000; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
3-to-8 one-hot decoder with active-high enable.
- Provides a zero-latency combinational output and a one-cycle registered copy of it.
- Used as the column/row select decoder in the LED array driver, where a 3-bit index selects one of up to 8 LED lines.

Parameters:
- None. Widths are fixed: 3-bit select, 8-bit one-hot output.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset; clears registered output.
- ena  input  1  decode enable, active-high.
- in   input  3  binary select index, 0..7.
- out  output 8  combinational one-hot decode of `in`, gated by `ena`.
- out_q  output 8  `out` registered on rising edge of `clk`.

Behaviour:
- Combinational path, `out`:
  - out[i] = ena AND (in == i), for i = 0..7.
  - ena=1: exactly one bit set, at position `in`. Example: in=3'd5 -> out=8'b0010_0000.
  - ena=0: out=8'h00 regardless of `in`.
  - No dependency on `clk` or `rst`. Reset does not force `out`.
  - Purely combinational; no latches.
- Registered path, `out_q`:
  - rst=1 asserts asynchronously: out_q=8'h00 immediately, without waiting for a clock edge.
  - While rst=1, out_q holds 8'h00.
  - rst=0: on each rising `clk` edge, out_q <= out (value of ena/in sampled at that edge). Latency exactly 1 cycle.
- Invariants:
  - out_q is always 8'h00 or exactly one-hot; never multi-hot.
  - Same holds for `out` whenever `ena` and `in` are known (no X/Z).
- Boundaries:
  - in=0 -> bit 0; in=7 -> bit 7. No wrap; all 8 codes valid.
  - ena and in changing in the same cycle: the registered value reflects both new values at the next edge.
  - Reset released between edges: out_q stays 8'h00 until the first rising edge after deassertion, then loads `out`.
  - Reset asserted mid-operation: out_q clears immediately; `out` unaffected.
- X/Z on `in` with ena=1: `out` is don't-care. Implementations need not propagate X specially.

Test Plan:
- Reset: rst=1 with ena=1, in=3'd4 -> out_q=8'h00 immediately and across 3 clocks, while out=8'h10.
- Exhaustive sweep: rst=0, ena=1, in=0..7 one per cycle -> out=8'h01,02,04,08,10,20,40,80 same cycle; out_q equals previous cycle's out.
- Enable gating: ena=0, in swept 0..7 -> out=8'h00 and out_q=8'h00 every cycle. Then ena=1, in=3'd2 -> out=8'h04 immediately, out_q=8'h04 after one edge.
- Simultaneous change: ena 1->0 with in 3->6 in the same cycle -> next out_q=8'h00. Then ena 0->1 with in=6 -> next out_q=8'h40.
- Async reset mid-run: out_q=8'h80, assert rst between clock edges -> out_q=8'h00 before the next edge. Deassert between edges with in=1, ena=1 -> out_q stays 8'h00 until the next rising edge, then 8'h02.
- One-hot check: random ena/in for 1000 cycles -> popcount(out_q) is 0 or 1 every cycle, and out_q equals the expected decode of the prior cycle's inputs.
